// File: rtl/instr_encoder.sv
// Encodes instruction commands into 32-bit MIPS words and streams them into
// instruction memory through a registered write port, padding the tail with NOPs.
module instr_encoder #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int unsigned PAD_NOPS = 4,
    localparam int unsigned IW      = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [2:0]    cmd_kind_i,
    input  logic [4:0]    cmd_rs_i,
    input  logic [4:0]    cmd_rt_i,
    input  logic [4:0]    cmd_rd_i,
    input  logic [5:0]    cmd_funct_i,
    input  logic [15:0]   cmd_imm_i,
    input  logic [25:0]   cmd_target_i,
    input  logic          cmd_last_i,
    output logic          imem_we_o,
    output logic [31:0]   imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic [IW-1:0] words_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          ovf_o
);
    localparam int unsigned   PW      = $clog2(PAD_NOPS + 2);
    localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
    localparam logic [PW-1:0] PAD_C   = PW'(PAD_NOPS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pad_q, pad_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic [31:0] enc;
    logic        legal;
    logic [31:0] cur_addr;
    logic        accept;

    always_comb begin
        legal = 1'b1;
        enc   = 32'h0;
        case (cmd_kind_i)
            3'd0:    enc = {6'b000000, cmd_rs_i, cmd_rt_i, cmd_rd_i, 5'b0, cmd_funct_i};
            3'd1:    enc = {6'b001000, cmd_rs_i, cmd_rt_i, cmd_imm_i};
            3'd2:    enc = {6'b101011, cmd_rs_i, cmd_rt_i, cmd_imm_i};
            3'd3:    enc = {6'b100011, cmd_rs_i, cmd_rt_i, cmd_imm_i};
            3'd4:    enc = {6'b000010, cmd_target_i};
            3'd5:    enc = {6'b000100, cmd_rs_i, cmd_rt_i, cmd_imm_i};
            default: legal = 1'b0;
        endcase
    end

    assign cmd_ready_o = (state_q == S_LOAD) && (idx_q < DEPTH_C);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cur_addr    = BASE + (32'(idx_q) << 2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    pad_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        wdata_d = enc;
                        idx_d   = idx_q + IW'(1);
                        if (!cmd_last_i && (idx_q + IW'(1) == DEPTH_C)) begin
                            state_d = S_DONE;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (cmd_last_i) begin
                        state_d = S_FLUSH;
                        pad_d   = '0;
                    end
                end
            end
            S_FLUSH: begin
                // Leave only once nothing is left to write, so done_o trails the last write.
                if ((pad_q < PAD_C) && (idx_q < DEPTH_C)) begin
                    we_d    = 1'b1;
                    addr_d  = cur_addr;
                    wdata_d = 32'h0;
                    idx_d   = idx_q + IW'(1);
                    pad_d   = pad_q + PW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pad_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every written word, NOPs included, advances the index, so it doubles as the word count.
    assign words_o      = idx_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued as commands are
// driven and checked in order as the write port fires; one task per scenario.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start4 = 1'b0;
    logic        valid = 1'b0, last = 1'b0;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;

    logic        ready, we, busy, done, err, ovf;
    logic [31:0] addr, wdata;
    logic [8:0]  words;
    logic        ready4, we4, busy4, done4, err4, ovf4;
    logic [31:0] addr4, wdata4;
    logic [2:0]  words4;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] q[$];
    logic [63:0] q4[$];

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_valid_i(valid), .cmd_ready_o(ready),
        .cmd_kind_i(kind), .cmd_rs_i(rs), .cmd_rt_i(rt), .cmd_rd_i(rd), .cmd_funct_i(funct),
        .cmd_imm_i(imm), .cmd_target_i(tgt), .cmd_last_i(last), .imem_we_o(we),
        .imem_addr_o(addr), .imem_wdata_o(wdata), .words_o(words), .busy_o(busy),
        .done_o(done), .err_o(err), .ovf_o(ovf)
    );

    instr_encoder #(.DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .cmd_valid_i(valid), .cmd_ready_o(ready4),
        .cmd_kind_i(kind), .cmd_rs_i(rs), .cmd_rt_i(rt), .cmd_rd_i(rd), .cmd_funct_i(funct),
        .cmd_imm_i(imm), .cmd_target_i(tgt), .cmd_last_i(last), .imem_we_o(we4),
        .imem_addr_o(addr4), .imem_wdata_o(wdata4), .words_o(words4), .busy_o(busy4),
        .done_o(done4), .err_o(err4), .ovf_o(ovf4)
    );

    // Write-port monitors: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (we === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected", addr, wdata);
            end else begin
                e = q.pop_front();
                if ({addr, wdata} !== e) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h", addr, wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (we4 === 1'b1) begin
            n_vec++;
            if (q4.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write4 got addr=%h data=%h, none expected", addr4, wdata4);
            end else begin
                e = q4.pop_front();
                if ({addr4, wdata4} !== e) begin
                    n_err++;
                    $display("FAIL write4 got addr=%h data=%h want addr=%h data=%h", addr4, wdata4, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                       input logic [25:0] g, input logic l);
        kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; tgt = g; last = l;
        valid = 1'b1;
    endtask

    task automatic idle_cmd();
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        @(negedge clk);
        n_vec++;
        if ({ready, we, addr, wdata, words, busy, done, err, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_state got %h want 0", {ready, we, addr, wdata, words, busy, done, err, ovf});
        end
        n_vec++;
        if ({ready4, we4, addr4, wdata4, words4, busy4, done4, err4, ovf4} !== '0) begin
            n_err++;
            $display("FAIL reset_state4 got %h want 0", {ready4, we4, addr4, wdata4, words4, busy4, done4, err4, ovf4});
        end
        tick(); rst = 1'b0;
    endtask

    task automatic test_single();
        pulse_start();
        @(negedge clk);
        n_vec++;
        if ({ready, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL start_ready got ready/busy=%b want 11", {ready, busy});
        end
        tick();
        q.push_back({32'h0, 32'h2001_0005});
        put(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
        tick(); idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({we, words} !== {1'b1, 9'd1}) begin
            n_err++;
            $display("FAIL single_latency got we=%b words=%0d want we=1 words=1", we, words);
        end
        tick(); do_reset();
    endtask

    task automatic test_jump_flush();
        pulse_start();
        q.push_back({32'h0, 32'h0800_0010});
        put(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0);
        tick();
        q.push_back({32'h4, 32'h1022_FFFF});
        put(3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
        tick(); idle_cmd();
        for (int i = 0; i < 4; i++) q.push_back({32'h8 + 32'(4 * i), 32'h0});
        @(negedge clk);
        n_vec++;
        if ({we, ready} !== 2'b10) begin
            n_err++;
            $display("FAIL last_ready got we/ready=%b want 10", {we, ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({we, done, busy} !== 3'b101) begin
                n_err++;
                $display("FAIL nop_%0d got we/done/busy=%b want 101", i, {we, done, busy});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({we, done, busy, words} !== {3'b010, 9'd6}) begin
            n_err++;
            $display("FAIL flush_done got we/done/busy=%b words=%0d want 010 words=6", {we, done, busy}, words);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        q.push_back({32'h0, 32'h0022_1820});
        put(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'd0, 26'd0, 1'b0);
        tick();
        q.push_back({32'h4, 32'hAC03_0008});
        put(3'd2, 5'd0, 5'd3, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (we !== 1'b1) begin n_err++; $display("FAIL b2b_0 got we=%b want 1", we); end
        tick();
        q.push_back({32'h8, 32'h8C04_0004});
        put(3'd3, 5'd0, 5'd4, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (we !== 1'b1) begin n_err++; $display("FAIL b2b_1 got we=%b want 1", we); end
        tick(); idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({we, words} !== {1'b1, 9'd3}) begin
            n_err++;
            $display("FAIL b2b_2 got we=%b words=%0d want we=1 words=3", we, words);
        end
    endtask

    task automatic test_illegal();
        tick();
        put(3'd7, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
        tick(); idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({we, err, words} !== {2'b01, 9'd3}) begin
            n_err++;
            $display("FAIL illegal got we/err=%b words=%0d want 01 words=3", {we, err}, words);
        end
        tick();
        q.push_back({32'hC, 32'h2045_1234});
        put(3'd1, 5'd2, 5'd5, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1);
        tick(); idle_cmd();
        for (int i = 0; i < 4; i++) q.push_back({32'h10 + 32'(4 * i), 32'h0});
        @(negedge clk);
        n_vec++;
        if (we !== 1'b1) begin n_err++; $display("FAIL after_illegal got we=%b want 1", we); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            put(3'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
            valid = (i % 2 == 0);
            @(negedge clk);
            n_vec++;
            if (ready !== 1'b0) begin n_err++; $display("FAIL flush_ready_%0d got %b want 0", i, ready); end
        end
        idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({done, err, words} !== {2'b11, 9'd8}) begin
            n_err++;
            $display("FAIL illegal_done got done/err=%b words=%0d want 11 words=8", {done, err}, words);
        end
        tick(); pulse_start();
        @(negedge clk);
        n_vec++;
        if ({err, done, words} !== {2'b00, 9'd0}) begin
            n_err++;
            $display("FAIL restart_clear got err/done=%b words=%0d want 00 words=0", {err, done}, words);
        end
        tick(); do_reset();
    endtask

    task automatic test_depth4();
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q4.push_back({32'(4 * i), 32'h2000_0000 | (32'(i) << 16) | 32'(i)});
            put(3'd1, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
            tick();
        end
        idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({we4, ovf4, ready4} !== 3'b110) begin
            n_err++;
            $display("FAIL ovf_write got we/ovf/ready=%b want 110", {we4, ovf4, ready4});
        end
        @(negedge clk);
        n_vec++;
        if ({done4, ovf4, ready4, words4} !== {3'b110, 3'd4}) begin
            n_err++;
            $display("FAIL ovf_done got done/ovf/ready=%b words=%0d want 110 words=4", {done4, ovf4, ready4}, words4);
        end
        tick(); start4 = 1'b1; tick(); start4 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ovf4, done4, ready4, words4} !== {3'b001, 3'd0}) begin
            n_err++;
            $display("FAIL ovf_clear got ovf/done/ready=%b words=%0d want 001 words=0", {ovf4, done4, ready4}, words4);
        end
        tick(); do_reset();
    endtask

    task automatic test_reset_flush();
        pulse_start();
        q.push_back({32'h0, 32'h2001_0005});
        put(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        tick(); idle_cmd();
        q.push_back({32'h4, 32'h0});
        q.push_back({32'h8, 32'h0});
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({we, addr} !== {1'b1, 32'h8}) begin
            n_err++;
            $display("FAIL second_nop got we=%b addr=%h want we=1 addr=00000008", we, addr);
        end
        tick(); rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ready, we, addr, wdata, words, busy, done, err, ovf} !== '0) begin
            n_err++;
            $display("FAIL mid_flush_reset got %h want 0", {ready, we, addr, wdata, words, busy, done, err, ovf});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({we, busy} !== 2'b00) begin n_err++; $display("FAIL post_reset_%0d got we/busy=%b want 00", i, {we, busy}); end
        end
        tick(); pulse_start();
        q.push_back({32'h0, 32'h2001_0005});
        put(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
        tick(); idle_cmd();
        @(negedge clk);
        n_vec++;
        if ({we, words} !== {1'b1, 9'd1}) begin
            n_err++;
            $display("FAIL restart_base got we=%b words=%0d want we=1 words=1", we, words);
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_jump_flush();
        test_back_to_back();
        test_illegal();
        test_depth4();
        test_reset_flush();
        n_vec++;
        if (q.size() != 0 || q4.size() != 0) begin
            n_err++;
            $display("FAIL pending_writes got %0d/%0d outstanding want 0/0", q.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes instruction commands (kind plus register, immediate and target fields) into 32-bit MIPS words and streams them into instruction memory through a registered write port. It is the write-side counterpart of the main decoder: every word it emits uses exactly the opcode set the decoder recognises. It sits between the testbench or boot loader and the instruction memory. It accepts commands over a valid/ready handshake, keeps a write address counter, pads the program tail with NOPs and flags illegal or overflowing input.

## Interface
Parameters:
- DEPTH, 256: instruction memory capacity in words.
- BASE, 32'h0000_0000: byte address of the first word.
- PAD_NOPS, 4: number of NOP words (32'h0) appended after the last command.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, synchronous, active-high.
- start_i in 1: begin a new program load.
- cmd_valid_i in 1: command valid.
- cmd_ready_o out 1: command ready.
- cmd_kind_i in 3: instruction kind. 0 R-type, 1 addi, 2 sw, 3 lw, 4 j, 5 beq, 6–7 illegal.
- cmd_rs_i in 5: rs field.
- cmd_rt_i in 5: rt field.
- cmd_rd_i in 5: rd field.
- cmd_funct_i in 6: funct field (R-type only).
- cmd_imm_i in 16: immediate (I-type).
- cmd_target_i in 26: jump target (j).
- cmd_last_i in 1: this command is the last of the program.
- imem_we_o out 1: memory write enable.
- imem_addr_o out 32: byte address.
- imem_wdata_o out 32: encoded word.
- words_o out log2(DEPTH)+1: words written since start, NOPs included.
- busy_o out 1: state is LOAD or FLUSH.
- done_o out 1: state is DONE.
- err_o out 1: sticky; an illegal kind was received.
- ovf_o out 1: sticky; memory filled before cmd_last.

## Operation
- States:
  - IDLE, the reset state.
  - LOAD
  - FLUSH
  - DONE
- IDLE/DONE + start_i: go to LOAD. Clear the index counter, words_o, err_o and ovf_o. start_i is ignored in LOAD and FLUSH.
- cmd_ready_o = (state==LOAD) && (index < DEPTH). It is combinational from state only and never depends on cmd_valid_i.
- Acceptance happens when cmd_valid_i && cmd_ready_o are both high at the clock edge. Encoding of an accepted command:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}.
  - addi: {6'b001000, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - lw: {6'b100011, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
  - j: {6'b000010, target}.
- Fields unused by the given kind are ignored.
- Legal accepted command: register the write (we, addr = BASE + 4*index, data), then increment index and words_o.
- Illegal kind: the handshake completes, no write occurs, index is unchanged and err_o is set.
- Accepted with cmd_last_i (legal or illegal): go to FLUSH.
- Legal accept without last that brings index to DEPTH: go to DONE and set ovf_o.
- FLUSH: write one 32'h0 per cycle at successive addresses until PAD_NOPS NOPs are written or index==DEPTH, then go to DONE. With PAD_NOPS=0 or index==DEPTH on entry, go directly to DONE with no writes.
- Width rules: index saturates at DEPTH and never wraps. imem_addr_o is 32-bit modulo arithmetic.
- rst_i in any state, including mid-LOAD or mid-FLUSH, returns to IDLE. Writes in flight are abandoned, not completed.

## Timing
- Reset values:
  - cmd_ready_o 0, imem_we_o 0, imem_addr_o 0, imem_wdata_o 0.
  - words_o 0, busy_o 0, done_o 0, err_o 0, ovf_o 0.
- Latency: a command accepted at edge N drives imem_we_o high during cycle N+1 with the encoded word. imem_we_o is high for exactly one cycle per written word.
- Throughput: one command per cycle. Back-to-back acceptance writes consecutive addresses on consecutive cycles.
- start_i at edge N: LOAD and cmd_ready_o=1 from cycle N+1.
- cmd_last accepted at edge N: cmd_ready_o=0 from cycle N+1. The first NOP write is visible in cycle N+2.
- done_o asserts in the cycle after the final write cycle. It stays high until start_i or rst_i.
- err_o and ovf_o hold until start_i or rst_i.

## Test plan
- Accept kind=1, rs=0, rt=1, imm=5 after start -> next cycle we=1, addr=0x0, data=0x20010005. words_o=1.
- Back-to-back commands:
  - R rs=1, rt=2, rd=3, funct=6'b100000 -> 0x00221820 @0x0.
  - sw rs=0, rt=3, imm=8 -> 0xAC030008 @0x4.
  - lw rs=0, rt=4, imm=4 -> 0x8C040004 @0x8.
  - Writes land on three consecutive cycles.
- j target=26'h10 -> 0x08000010. beq rs=1, rt=2, imm=16'hFFFF with last=1 -> 0x1022FFFF, then 4 NOPs at the next 4 addresses, then done_o=1 and words_o=6.
- kind=7 accepted -> no write, err_o=1, next legal word at the same address. Toggle cmd_valid_i while FLUSH is active -> cmd_ready_o stays 0 and no extra writes occur.
- DEPTH=4: 4 legal commands without last -> 4 writes @0x0–0xC, ovf_o=1, done_o=1, cmd_ready_o=0, then start_i clears the flags.
- rst_i asserted during the second NOP of FLUSH -> all outputs return to reset values next cycle with no further writes. start_i then restarts at addr BASE.
